// File: rtl/mcore_mem_resp_net_sched.sv
// Round-robin scheduler of bank response messages onto one network injection port.
// Inserts one dead (scrub) cycle whenever the forwarded security domain changes.
module mcore_mem_resp_net_sched #(
   parameter int unsigned p_num_reqs   = 4,
   parameter int unsigned p_ctrl_nbits = 23,
   parameter int unsigned p_data_nbits = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [p_num_reqs-1:0]                in_val,
   output logic [p_num_reqs-1:0]                in_rdy,
   input  logic [p_num_reqs-1:0]                in_domain,
   input  logic [p_num_reqs*p_ctrl_nbits-1:0]   in_control,
   input  logic [p_num_reqs*p_data_nbits-1:0]   in_data,
   output logic                                 out_val,
   input  logic                                 out_rdy,
   output logic                                 out_domain,
   output logic [p_ctrl_nbits-1:0]              out_control,
   output logic [p_data_nbits-1:0]              out_data
);

   localparam int unsigned NR = p_num_reqs;
   localparam int unsigned CN = p_ctrl_nbits;
   localparam int unsigned DN = p_data_nbits;
   localparam int unsigned PW = $clog2(NR);
   localparam int unsigned SW = PW + 1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SCRUB = 2'd2
   } state_e;

   typedef struct packed {
      logic          dom;
      logic [CN-1:0] ctrl;
      logic [DN-1:0] data;
   } msg_t;

   state_e        state_q, state_d;
   logic          last_domain_q, last_domain_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic          out_val_q, out_val_d;
   msg_t          out_q, out_d;

   logic          gnt_found;
   logic [PW-1:0] gnt_idx;
   logic [SW-1:0] scan_w;
   msg_t          sel_msg;
   logic          drain;
   logic          slot_free;
   logic [NR-1:0] in_rdy_c;

   // First valid requester at or after rr_ptr, wrapping modulo NR
   always_comb begin : grant_search
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_w    = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         scan_w = SW'(rr_ptr_q) + SW'(k);
         if (scan_w >= SW'(NR)) begin
            scan_w = scan_w - SW'(NR);
         end
         if (!gnt_found && in_val[scan_w[PW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_w[PW-1:0];
         end
      end
   end

   // Select the granted requester's message (only ever captured into a flop)
   always_comb begin : grant_mux
      sel_msg = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (gnt_idx == PW'(i)) begin
            sel_msg.dom  = in_domain[i];
            sel_msg.ctrl = in_control[i*CN +: CN];
            sel_msg.data = in_data[i*DN +: DN];
         end
      end
   end

   // Next-state, output slot and handshake logic
   always_comb begin : fsm_next
      state_d       = state_q;
      last_domain_d = last_domain_q;
      rr_ptr_d      = rr_ptr_q;
      out_val_d     = out_val_q;
      out_d         = out_q;
      in_rdy_c      = '0;
      drain         = out_val_q & out_rdy;
      slot_free     = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & drain);

      unique case (state_q)
         ST_SCRUB: begin
            state_d = ST_EMPTY;
         end
         default: begin
            if (drain) begin
               state_d      = ST_EMPTY;
               out_val_d    = 1'b0;
               out_d.ctrl   = '0;
               out_d.data   = '0;
            end
            if (slot_free && gnt_found) begin
               if (sel_msg.dom == last_domain_q) begin
                  in_rdy_c  = NR'(1) << gnt_idx;
                  state_d   = ST_FULL;
                  out_val_d = 1'b1;
                  out_d     = sel_msg;
                  rr_ptr_d  = (gnt_idx == PW'(NR-1)) ? '0 : gnt_idx + PW'(1);
               end else begin
                  // Domain change: burn one empty cycle before serving the new domain
                  state_d       = ST_SCRUB;
                  last_domain_d = sel_msg.dom;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin : state_regs
      if (!reset) begin
         state_q       <= ST_EMPTY;
         last_domain_q <= 1'b0;
         rr_ptr_q      <= '0;
         out_val_q     <= 1'b0;
         out_q         <= '0;
      end else begin
         state_q       <= state_d;
         last_domain_q <= last_domain_d;
         rr_ptr_q      <= rr_ptr_d;
         out_val_q     <= out_val_d;
         out_q         <= out_d;
      end
   end

   assign in_rdy      = in_rdy_c & {NR{reset}};
   assign out_val     = out_val_q;
   assign out_domain  = out_q.dom;
   assign out_control = out_q.ctrl;
   assign out_data    = out_q.data;

endmodule

// File: tb/tb_mcore_mem_resp_net_sched.sv
// Self-checking bench for mcore_mem_resp_net_sched: directed vector table, hand
// sequences for reset/mixed-domain corners, and random traffic against a slot model.
module tb_mcore_mem_resp_net_sched;

   localparam int N  = 4;
   localparam int CN = 23;
   localparam int DN = 32;

   logic            clk;
   logic            reset;
   logic [N-1:0]    in_val;
   logic [N-1:0]    in_rdy;
   logic [N-1:0]    in_domain;
   logic [N*CN-1:0] in_control;
   logic [N*DN-1:0] in_data;
   logic            out_val;
   logic            out_rdy;
   logic            out_domain;
   logic [CN-1:0]   out_control;
   logic [DN-1:0]   out_data;

   logic [CN-1:0]   ctl_a [N];
   logic [DN-1:0]   dat_a [N];

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: one optional held message plus a pending-scrub flag
   bit            m_has;
   logic [CN-1:0] m_ctl;
   logic [DN-1:0] m_dat;
   logic          m_dom;
   bit            m_last;
   int            m_ptr;
   bit            m_scrub;
   logic [CN-1:0] m_q[$];
   logic [CN-1:0] dut_q[$];
   bit            prev_oval;
   logic          prev_odom;

   typedef struct {
      logic [N-1:0]  val;
      logic [N-1:0]  dom;
      logic          ordy;
      logic [N-1:0]  exp_rdy;
      logic          exp_oval;
      logic [CN-1:0] exp_ctrl;
   } vec_t;

   vec_t tbl [22];

   mcore_mem_resp_net_sched #(
      .p_num_reqs  (N),
      .p_ctrl_nbits(CN),
      .p_data_nbits(DN)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_val     (in_val),
      .in_rdy     (in_rdy),
      .in_domain  (in_domain),
      .in_control (in_control),
      .in_data    (in_data),
      .out_val    (out_val),
      .out_rdy    (out_rdy),
      .out_domain (out_domain),
      .out_control(out_control),
      .out_data   (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      in_control = '0;
      in_data    = '0;
      for (int i = 0; i < N; i++) begin
         in_control[i*CN +: CN] = ctl_a[i];
         in_data[i*DN +: DN]    = dat_a[i];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int find_g();
      for (int k = 0; k < N; k++) begin
         if (in_val[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic bit model_free();
      return !m_scrub && (!m_has || out_rdy);
   endfunction

   task automatic model_reset();
      m_has = 0; m_ctl = '0; m_dat = '0; m_dom = 0;
      m_last = 0; m_ptr = 0; m_scrub = 0; prev_oval = 0;
   endtask

   task automatic model_check();
      int g;
      logic [N-1:0] exp_rdy;
      g = find_g();
      exp_rdy = '0;
      if (model_free() && g >= 0 && in_domain[g] == m_last) exp_rdy[g] = 1'b1;
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      chk("out_val", 64'(out_val), 64'(m_has));
      chk("out_control", 64'(out_control), m_has ? 64'(m_ctl) : 64'd0);
      chk("out_data", 64'(out_data), m_has ? 64'(m_dat) : 64'd0);
      if (m_has) chk("out_domain", 64'(out_domain), 64'(m_dom));
      if (out_val && prev_oval) chk("adjacent_domain", 64'(out_domain), 64'(prev_odom));
      if (out_val && out_rdy) dut_q.push_back(out_control);
      prev_oval = out_val;
      prev_odom = out_domain;
   endtask

   task automatic model_advance();
      int g;
      bit free;
      g    = find_g();
      free = model_free();
      if (m_scrub) begin
         m_scrub = 0;
      end else begin
         if (m_has && out_rdy) begin
            m_q.push_back(m_ctl);
            m_has = 0;
         end
         if (free && g >= 0) begin
            if (in_domain[g] == m_last) begin
               m_has = 1; m_ctl = ctl_a[g]; m_dat = dat_a[g]; m_dom = in_domain[g];
               m_ptr = (g + 1) % N;
            end else begin
               m_scrub = 1;
               m_last  = in_domain[g];
            end
         end
      end
   endtask

   task automatic cycle_end();
      model_check();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      cycle_end();
   endtask

   initial begin
      logic dom_base;

      tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 23'h0};
      tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 23'h100};
      tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 23'h101};
      tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 23'h102};
      tbl[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 23'h103};
      for (int r = 5; r < 10; r++) tbl[r] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 23'h100};
      tbl[10] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 23'h100};
      tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 23'h102};
      tbl[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 23'h0};
      tbl[13] = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 23'h0};
      tbl[14] = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 23'h0};
      tbl[15] = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 23'h0};
      tbl[16] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 23'h101};
      tbl[17] = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b1, 23'h101};
      tbl[18] = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 23'h0};
      tbl[19] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 23'h0};
      tbl[20] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 23'h100};
      tbl[21] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 23'h0};

      for (int i = 0; i < N; i++) begin
         ctl_a[i] = 23'h100 + 23'(i);
         dat_a[i] = 32'hA000_0000 + 32'(i);
      end
      dat_a[1] = 32'hDEAD_BEEF;

      // T1: reset held with every requester valid
      reset = 1'b0; in_val = 4'b1111; in_domain = '0; out_rdy = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_rdy", 64'(in_rdy), 64'd0);
      chk("rst_out_val", 64'(out_val), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_control", 64'(out_control), 64'd0);
      reset = 1'b1;

      // T2-T4: directed vector table
      for (int r = 0; r < 22; r++) begin
         in_val = tbl[r].val; in_domain = tbl[r].dom; out_rdy = tbl[r].ordy;
         @(negedge clk);
         chk($sformatf("tbl%0d_rdy", r), 64'(in_rdy), 64'(tbl[r].exp_rdy));
         chk($sformatf("tbl%0d_oval", r), 64'(out_val), 64'(tbl[r].exp_oval));
         chk($sformatf("tbl%0d_ctrl", r), 64'(out_control), 64'(tbl[r].exp_ctrl));
         if (r == 16) begin
            chk("t4_data", 64'(out_data), 64'hDEAD_BEEF);
            chk("t4_domain", 64'(out_domain), 64'd1);
         end
         cycle_end();
      end

      // T5: two always-valid requesters in opposite domains
      m_q.delete(); dut_q.delete();
      in_val = 4'b0011; in_domain = 4'b0010; out_rdy = 1'b1;
      repeat (40) step();
      chk("t5_count", 64'(dut_q.size()), 64'(m_q.size()));
      chk("t5_progress", 64'(dut_q.size() >= 10), 64'd1);
      for (int i = 1; i < dut_q.size(); i++) begin
         chk("t5_alternate", 64'(dut_q[i][0] != dut_q[i-1][0]), 64'd1);
      end
      in_val = '0;
      repeat (3) step();

      // Random traffic with mostly-stable domains and random backpressure
      dom_base = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) dom_base = ~dom_base;
         in_val    = 4'($urandom);
         in_domain = ($urandom_range(0, 5) == 0) ? 4'($urandom) : {N{dom_base}};
         out_rdy   = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            ctl_a[i] = 23'($urandom);
            dat_a[i] = $urandom;
         end
         step();
      end

      // T6: asynchronous reset while FULL and backpressured
      in_val = 4'b1111; in_domain = {N{m_last}}; out_rdy = 1'b0;
      repeat (3) step();
      chk("t6_full_before", 64'(out_val), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_out_val_drop", 64'(out_val), 64'd0);
      chk("t6_in_rdy", 64'(in_rdy), 64'd0);
      chk("t6_out_data", 64'(out_data), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      in_val = '0; out_rdy = 1'b1;
      reset = 1'b1;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
